// File: rtl/adder_char_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_char_pkg
//  Description : Shared types and defaults for the adder characterization
//                traffic injector (FSM states, pattern modes, default sizing,
//                default 50-bit LFSR feedback mask).
//  Revision    : 1.0 - initial release
// ============================================================================
package adder_char_pkg;

  // Injector FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Pattern source select
  localparam logic c_mode_lfsr  = 1'b0;
  localparam logic c_mode_therm = 1'b1;

  // Default sizing
  localparam int c_def_n       = 25;
  localparam int c_def_payload = 20;
  localparam int c_def_gap     = 7;
  localparam int c_def_num_pkt = 10;
  localparam int c_def_stride  = 6;

  // Maximal-length feedback for a 50-bit Fibonacci LFSR: bits 49,48,23,22
  localparam logic [49:0] c_def_taps = 50'h3_0000_00C0_0000;

  // Thermometer fill level for flit index f: (f*stride) mod (width+1)
  function automatic int therm_level(input int f, input int stride, input int width);
    return (f * stride) % (width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_gen
//  Description : 2N-bit operand pattern source. Holds a Fibonacci LFSR and a
//                stepped thermometer generator. The word output is a
//                look-ahead: it already reflects a load/advance requested in
//                the current cycle, so the caller can register it on the
//                same edge that commits the LFSR update.
//  Revision    : 1.0 - initial release
// ============================================================================
module pattern_gen
  import adder_char_pkg::*;
#(
  parameter int             N      = c_def_n,
  parameter int             STRIDE = c_def_stride,
  parameter int             FIDX_W = 5,
  parameter logic [2*N-1:0] SEED   = {{(2*N-1){1'b0}}, 1'b1},
  parameter logic [2*N-1:0] TAPS   = c_def_taps
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  logic              mode,
  input  logic [FIDX_W-1:0] fidx,
  output logic [2*N-1:0]    word
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1
  localparam logic [2*N-1:0] c_seed = (SEED == '0) ? {{(2*N-1){1'b0}}, 1'b1} : SEED;

  logic [2*N-1:0] r_lfsr;
  logic [2*N-1:0] w_lfsr_d;
  logic           w_feedback;
  logic [2*N-1:0] w_base;
  logic [2*N-1:0] w_therm;
  int             w_level;

  // LFSR next value: reload on load, shift-left with parity feedback on advance
  always_comb begin
    w_feedback = ^(r_lfsr & TAPS);
    w_lfsr_d   = r_lfsr;
    if (load) begin
      w_lfsr_d = c_seed;
    end else if (advance) begin
      w_lfsr_d = {r_lfsr[2*N-2:0], w_feedback};
    end
  end

  // LFSR state register; persists across packets
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= c_seed;
    end else begin
      r_lfsr <= w_lfsr_d;
    end
  end

  // Thermometer: lowest w_level bits set, inverted on odd flits
  assign w_level = therm_level(int'(fidx), STRIDE, 2*N);

  for (genvar gi = 0; gi < 2*N; gi++) begin : g_therm_bit
    assign w_base[gi] = (w_level > gi);
  end

  assign w_therm = fidx[0] ? ~w_base : w_base;
  assign word    = (mode == c_mode_therm) ? w_therm : w_lfsr_d;

endmodule
`default_nettype wire

// File: rtl/adder_flit_injector.sv
`default_nettype none
// ============================================================================
//  Module      : adder_flit_injector
//  Description : Packet-based operand injector for adder energy
//                characterization. Sends NUM_PKT packets of PAYLOAD flits
//                separated by GAP idle cycles, with valid/ready handshake.
//                input1/input2 are the low/high halves of the pattern word
//                and hold steady whenever no new flit is presented.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_flit_injector
  import adder_char_pkg::*;
#(
  parameter int             N       = c_def_n,
  parameter int             PAYLOAD = c_def_payload,
  parameter int             GAP     = c_def_gap,
  parameter int             NUM_PKT = c_def_num_pkt,
  parameter int             STRIDE  = c_def_stride,
  parameter logic [2*N-1:0] SEED    = {{(2*N-1){1'b0}}, 1'b1},
  parameter logic [2*N-1:0] TAPS    = c_def_taps
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         mode,
  input  logic                         ready,
  output logic                         valid,
  output logic [N-1:0]                 input1,
  output logic [N-1:0]                 input2,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(NUM_PKT+1)-1:0] pkt_cnt,
  output logic [$clog2(PAYLOAD+1)-1:0] flit_cnt
);

  localparam int c_flit_w = $clog2(PAYLOAD + 1);
  localparam int c_pkt_w  = $clog2(NUM_PKT + 1);
  localparam int c_gap_w  = (GAP > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [c_flit_w-1:0] c_last_flit = c_flit_w'(PAYLOAD - 1);
  localparam logic [c_pkt_w-1:0]  c_last_pkt  = c_pkt_w'(NUM_PKT - 1);
  localparam logic [c_gap_w-1:0]  c_last_gap  = c_gap_w'((GAP > 0) ? GAP - 1 : 0);

  state_t              r_state;
  state_t              w_state_d;
  logic                r_mode;
  logic                r_arm;
  logic [c_flit_w-1:0] r_flit_cnt;
  logic [c_flit_w-1:0] w_flit_d;
  logic [c_pkt_w-1:0]  r_pkt_cnt;
  logic [c_pkt_w-1:0]  w_pkt_d;
  logic [c_gap_w-1:0]  r_gap_cnt;
  logic [c_gap_w-1:0]  w_gap_d;
  logic                r_valid;
  logic                r_busy;
  logic                r_done;
  logic                w_valid_d;
  logic                w_busy_d;
  logic                w_done_d;
  logic                w_word_en;
  logic [2*N-1:0]      r_word;
  logic [2*N-1:0]      w_word;
  logic                w_start_ok;
  logic                w_accept;
  logic                w_last_flit;
  logic                w_last_pkt;

  // A start is taken once in IDLE; r_arm blocks re-sampling during the
  // single setup cycle so mode cannot be re-latched before SEND.
  assign w_start_ok  = (r_state == ST_IDLE) && start && !r_arm;
  assign w_accept    = (r_state == ST_SEND) && r_valid && ready;
  assign w_last_flit = (r_flit_cnt == c_last_flit);
  assign w_last_pkt  = (r_pkt_cnt == c_last_pkt);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_arm) begin
          w_state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_accept && w_last_flit) begin
          if (w_last_pkt) begin
            w_state_d = ST_DONE;
          end else if (GAP > 0) begin
            w_state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == c_last_gap) begin
          w_state_d = ST_SEND;
        end
      end
      ST_DONE: begin
        w_state_d = ST_IDLE;
      end
      default: begin
        w_state_d = ST_IDLE;
      end
    endcase
  end

  // Output/datapath control decode from the upcoming state
  always_comb begin
    w_valid_d = (w_state_d == ST_SEND);
    w_busy_d  = (w_state_d == ST_SEND) || (w_state_d == ST_GAP);
    w_done_d  = (w_state_d == ST_DONE);
    // New word on entry to SEND or after an accept that stays in SEND;
    // otherwise the operands hold so the adder sees no spurious toggles.
    w_word_en = (w_state_d == ST_SEND) && ((r_state != ST_SEND) || w_accept);
  end

  // Counter next values: flit index, packets sent, gap length
  always_comb begin
    w_flit_d = r_flit_cnt;
    w_pkt_d  = r_pkt_cnt;
    w_gap_d  = '0;
    if (w_start_ok) begin
      w_flit_d = '0;
      w_pkt_d  = '0;
    end else if (w_accept) begin
      if (w_last_flit) begin
        w_flit_d = '0;
        w_pkt_d  = r_pkt_cnt + 1'b1;
      end else begin
        w_flit_d = r_flit_cnt + 1'b1;
      end
    end
    if (r_state == ST_GAP) begin
      w_gap_d = r_gap_cnt + 1'b1;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flit_cnt <= '0;
      r_pkt_cnt  <= '0;
      r_gap_cnt  <= '0;
    end else begin
      r_flit_cnt <= w_flit_d;
      r_pkt_cnt  <= w_pkt_d;
      r_gap_cnt  <= w_gap_d;
    end
  end

  // Run setup: latch mode and arm the IDLE->SEND move on an accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= c_mode_lfsr;
      r_arm  <= 1'b0;
    end else begin
      r_arm <= w_start_ok;
      if (w_start_ok) begin
        r_mode <= mode;
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_word  <= '0;
    end else begin
      r_valid <= w_valid_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
      if (w_word_en) begin
        r_word <= w_word;
      end
    end
  end

  // The pattern index is the flit about to be presented, hence w_flit_d
  pattern_gen #(
    .N      (N),
    .STRIDE (STRIDE),
    .FIDX_W (c_flit_w),
    .SEED   (SEED),
    .TAPS   (TAPS)
  ) u_pattern_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (w_start_ok),
    .advance (w_accept),
    .mode    (r_mode),
    .fidx    (w_flit_d),
    .word    (w_word)
  );

  assign valid    = r_valid;
  assign busy     = r_busy;
  assign done     = r_done;
  assign input1   = r_word[N-1:0];
  assign input2   = r_word[2*N-1:N];
  assign pkt_cnt  = r_pkt_cnt;
  assign flit_cnt = r_flit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_adder_flit_injector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder_flit_injector
//  Description : Self-checking bench for adder_flit_injector. A default-sized
//                instance is checked against a reference pattern model via a
//                scoreboard of expected accepted words; a small instance
//                (PAYLOAD=1, GAP=0, NUM_PKT=3) covers the back-to-back case.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_flit_injector;

  localparam logic [49:0] TB_TAPS = 50'h3_0000_00C0_0000;

  logic        clk = 1'b0;
  logic        rst_n;

  // default instance
  logic        start, mode, ready;
  logic        valid, busy, done;
  logic [24:0] input1, input2;
  logic [3:0]  pkt_cnt;
  logic [4:0]  flit_cnt;

  // small instance
  logic        start_s, mode_s, ready_s;
  logic        valid_s, busy_s, done_s;
  logic [24:0] in1_s, in2_s;
  logic [1:0]  pkt_cnt_s;
  logic [0:0]  flit_cnt_s;

  int          checks = 0;
  int          errors = 0;
  logic [49:0] exp_q[$];
  logic [49:0] m_lfsr;
  logic        held;
  logic [49:0] held_word;

  adder_flit_injector dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .ready(ready),
    .valid(valid), .input1(input1), .input2(input2), .busy(busy),
    .done(done), .pkt_cnt(pkt_cnt), .flit_cnt(flit_cnt)
  );

  adder_flit_injector #(.PAYLOAD(1), .GAP(0), .NUM_PKT(3)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(start_s), .mode(mode_s), .ready(ready_s),
    .valid(valid_s), .input1(in1_s), .input2(in2_s), .busy(busy_s),
    .done(done_s), .pkt_cnt(pkt_cnt_s), .flit_cnt(flit_cnt_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [49:0] lfsr_step(input logic [49:0] w);
    return {w[48:0], ^(w & TB_TAPS)};
  endfunction

  function automatic logic [49:0] therm_word(input int f);
    int          t;
    logic [49:0] base;
    t = (f * 6) % 51;
    if (t >= 50) base = {50{1'b1}};
    else         base = (50'd1 << t) - 50'd1;
    return (f % 2 == 1) ? ~base : base;
  endfunction

  task automatic push_lfsr(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(m_lfsr);
      m_lfsr = lfsr_step(m_lfsr);
    end
  endtask

  task automatic wait_done(input int budget, input bit toggle, input string tag);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
      if (toggle) ready = ~ready;
    end
    chk(tag, 64'(done), 64'(1));
  endtask

  // Scoreboard monitor: compares every accepted flit, and checks that a
  // stalled flit is re-presented unchanged on the following cycle.
  always @(negedge clk) begin : mon
    logic [49:0] cur;
    cur = {input2, input1};
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (valid && held) chk("stall_hold", 64'(cur), 64'(held_word));
      if (valid && ready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL sb_underflow observed=0x%0h expected=none", cur);
        end
        if (exp_q.size() != 0) chk("sb_word", 64'(cur), 64'(exp_q.pop_front()));
        held = 1'b0;
      end else if (valid) begin
        held      = 1'b1;
        held_word = cur;
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    int          pat_err;
    int          done_seen;
    int          n;
    logic        exp_v;
    logic [49:0] s_exp;

    rst_n = 1'b0;
    start = 1'b0; mode = 1'b0; ready = 1'b0;
    start_s = 1'b0; mode_s = 1'b0; ready_s = 1'b0;
    held = 1'b0; held_word = '0;
    tick(); tick();

    // ---------------- reset state ----------------
    chk("rst_outputs", 64'({valid, busy, done, input1, input2, pkt_cnt, flit_cnt}), 64'(0));
    chk("rst_outputs_small", 64'({valid_s, busy_s, done_s, in1_s, in2_s, pkt_cnt_s, flit_cnt_s}), 64'(0));
    rst_n = 1'b1;
    tick();

    // ---------------- A: thermometer full run, ready=1 ----------------
    for (int p = 0; p < 10; p++)
      for (int f = 0; f < 20; f++) exp_q.push_back(therm_word(f));
    mode = 1'b1; ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_lat_edge_k", 64'(valid), 64'(0));
    tick();
    pat_err = 0; done_seen = 0;
    for (int i = 0; i < 263; i++) begin
      if (i > 0) tick();
      exp_v = ((i % 27) < 20);
      if (valid !== exp_v || busy !== 1'b1) pat_err++;
      if (done) done_seen++;
      if (i == 0) chk("therm_f0", 64'({input2, input1}), 64'(0));
      if (i == 1) chk("therm_f1", 64'({input2, input1}), 64'({25'h1FFFFFF, 25'h1FFFFC0}));
      if (i == 2) chk("therm_f2", 64'({input2, input1}), 64'({25'h0, 25'h0000FFF}));
      if (i == 20) chk("gap_hold_first", 64'({input2, input1}), 64'(therm_word(19)));
      if (i == 26) chk("gap_hold_last", 64'({input2, input1}), 64'(therm_word(19)));
    end
    chk("valid_busy_pattern", 64'(pat_err), 64'(0));
    chk("done_early", 64'(done_seen), 64'(0));
    tick();
    chk("done_at_263", 64'({done, valid, busy}), 64'(3'b100));
    chk("pkt_cnt_final", 64'(pkt_cnt), 64'(10));
    chk("flit_cnt_final", 64'(flit_cnt), 64'(0));
    tick();
    chk("done_one_cycle", 64'(done), 64'(0));
    chk("sb_drain_A", 64'(exp_q.size()), 64'(0));

    // ---------------- B: LFSR, ready toggling, mid-run start/mode ----------------
    m_lfsr = 50'd1;
    push_lfsr(200);
    mode = 1'b0; ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("lfsr_w0", 64'({input2, input1}), 64'(1));
    ready = 1'b1;
    tick();
    chk("lfsr_w1", 64'({input2, input1}), 64'(2));
    for (int i = 0; i < 60; i++) begin
      ready = ~ready;
      if (i == 30) begin start = 1'b1; mode = 1'b1; end
      if (i == 31) start = 1'b0;
      tick();
    end
    wait_done(2000, 1'b1, "done_B");
    chk("pkt_cnt_B", 64'(pkt_cnt), 64'(10));
    mode = 1'b0; ready = 1'b1;
    tick();
    chk("sb_drain_B", 64'(exp_q.size()), 64'(0));

    // ---------------- C: reset during GAP of packet 4, then restart ----------------
    m_lfsr = 50'd1;
    push_lfsr(80);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(pkt_cnt == 4'd4 && busy && !valid) && n < 400) begin
      tick();
      n++;
    end
    chk("reach_gap4", 64'(pkt_cnt == 4'd4 && busy && !valid), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", 64'({valid, busy, done, input1, input2, pkt_cnt, flit_cnt}), 64'(0));
    tick(); tick();
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done || valid) done_seen++;
    end
    chk("no_done_after_rst", 64'(done_seen), 64'(0));
    chk("sb_drain_C", 64'(exp_q.size()), 64'(0));
    m_lfsr = 50'd1;
    push_lfsr(200);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("restart_word0", 64'({input2, input1}), 64'(1));
    chk("restart_flit_cnt", 64'(flit_cnt), 64'(0));
    wait_done(1000, 1'b0, "done_C");
    tick();
    chk("sb_drain_C2", 64'(exp_q.size()), 64'(0));

    // ---------------- D: PAYLOAD=1, GAP=0, NUM_PKT=3 ----------------
    s_exp = 50'd1;
    mode_s = 1'b0; ready_s = 1'b1; start_s = 1'b1;
    tick();
    start_s = 1'b0;
    tick();
    for (int j = 0; j < 3; j++) begin
      chk("small_valid", 64'({valid_s, busy_s, done_s}), 64'(3'b110));
      chk("small_word", 64'({in2_s, in1_s}), 64'(s_exp));
      chk("small_pkt_cnt", 64'(pkt_cnt_s), 64'(j));
      s_exp = lfsr_step(s_exp);
      tick();
    end
    chk("small_done", 64'({valid_s, busy_s, done_s}), 64'(3'b001));
    chk("small_counts", 64'({pkt_cnt_s, flit_cnt_s}), 64'({2'd3, 1'b0}));
    tick();
    chk("small_idle", 64'({valid_s, busy_s, done_s}), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
